// File: rtl/pe_ctrl_pkg.sv
// Shared constants for the PE sequencer: default parameters and FSM state encoding.
package pe_ctrl_pkg;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_CNT_W      = 8;
    localparam int unsigned DEF_PE_LAT     = 3;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Every state other than IDLE counts as working on a job.
    function automatic logic is_busy(input logic [2:0] st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// Job, operand, PE-side and result signals of the PE sequencer.
interface pe_seq_ctrl_if
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DATA_W-1:0] cfg_weight;
    logic [CNT_W-1:0]  cfg_count;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_ifmap;
    logic [DATA_W-1:0] in_psum;

    logic              pe_load_en;
    logic [DATA_W-1:0] pe_weight;
    logic [DATA_W-1:0] pe_ifmap;
    logic [DATA_W-1:0] pe_psum;
    logic [DATA_W-1:0] pe_psum_out;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    logic              busy;
    logic              done;

    modport slave (
        input  cfg_valid, cfg_weight, cfg_count, in_valid, in_ifmap, in_psum,
               pe_psum_out, out_ready,
        output cfg_ready, in_ready, pe_load_en, pe_weight, pe_ifmap, pe_psum,
               out_valid, out_data, out_last, busy, done
    );

    modport master (
        output cfg_valid, cfg_weight, cfg_count, in_valid, in_ifmap, in_psum,
               pe_psum_out, out_ready,
        input  cfg_ready, in_ready, pe_load_en, pe_weight, pe_ifmap, pe_psum,
               out_valid, out_data, out_last, busy, done
    );

endinterface

// File: rtl/pe_seq_ctrl_result_fifo.sv
// Synchronous result buffer; head reads as zero while empty.
module pe_result_fifo #(
    parameter int unsigned W     = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;

    assign pop_ok = pop && (count != '0);

    // Pointer and occupancy tracking; push and pop may coincide at any level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end

    // Storage array, written only on push.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/pe_seq_ctrl.sv
// Sequences one weight-stationary job through an external pe_fp16 with credit-based buffering.
module pe_seq_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned PE_LAT     = DEF_PE_LAT,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    pe_seq_ctrl_if.slave  bus
);
    localparam int unsigned UW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FW = DATA_W + 1;

    logic [2:0]        state, state_nxt;
    logic [CNT_W-1:0]  count_q, count_nxt;
    logic [CNT_W-1:0]  rem_q, rem_nxt;
    logic [CNT_W-1:0]  push_cnt_q, push_cnt_nxt;
    logic [UW-1:0]     used_q, used_nxt;
    logic [PE_LAT-1:0] tag_q, tag_nxt;
    logic              op_vld_q;
    logic [DATA_W-1:0] ifmap_q, ifmap_nxt;
    logic [DATA_W-1:0] psum_q, psum_nxt;
    logic [DATA_W-1:0] weight_q, weight_nxt;
    logic              cfg_ready_q, cfg_ready_nxt;
    logic              in_ready_q, in_ready_nxt;
    logic              load_en_q, load_en_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;

    logic              acc, cfg_acc, push, pop, fifo_ne, last_in;
    logic [FW-1:0]     fifo_head;
    logic [UW-1:0]     fifo_count;

    assign cfg_acc = bus.cfg_valid && cfg_ready_q;
    assign acc     = bus.in_valid && in_ready_q;
    assign push    = tag_q[PE_LAT-1];
    assign fifo_ne = (fifo_count != '0);
    assign pop     = fifo_ne && bus.out_ready;
    assign last_in = (push_cnt_q == count_q - CNT_W'(1));

    // Next-state and next-output decode; used_q tracks inflight plus buffered results.
    always_comb begin
        state_nxt    = state;
        count_nxt    = count_q;
        rem_nxt      = rem_q;
        push_cnt_nxt = push ? push_cnt_q + CNT_W'(1) : push_cnt_q;
        used_nxt     = used_q + UW'(acc) - UW'(pop);
        weight_nxt   = '0;
        tag_nxt[0]   = op_vld_q;
        for (int unsigned i = 1; i < PE_LAT; i++) tag_nxt[i] = tag_q[i-1];

        case (state)
            ST_IDLE: begin
                if (cfg_acc) begin
                    state_nxt    = ST_LOAD;
                    count_nxt    = bus.cfg_count;
                    rem_nxt      = bus.cfg_count;
                    push_cnt_nxt = '0;
                    weight_nxt   = bus.cfg_weight;
                end
            end
            ST_LOAD:   state_nxt = (rem_q != '0) ? ST_STREAM : ST_DRAIN;
            ST_STREAM: begin
                if (acc) begin
                    rem_nxt = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_q == '0) begin
                    if (!op_vld_q && (tag_q == '0)) state_nxt = ST_DONE;
                end else if (pop && fifo_head[DATA_W]) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase

        cfg_ready_nxt = (state_nxt == ST_IDLE);
        in_ready_nxt  = (state_nxt == ST_STREAM) && (used_nxt < UW'(FIFO_DEPTH));
        load_en_nxt   = (state_nxt == ST_LOAD);
        busy_nxt      = is_busy(state_nxt);
        done_nxt      = (state_nxt == ST_DONE);
        ifmap_nxt     = acc ? bus.in_ifmap : '0;
        psum_nxt      = acc ? bus.in_psum : '0;
    end

    // State, counters, issue pipeline and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            push_cnt_q  <= '0;
            used_q      <= '0;
            tag_q       <= '0;
            op_vld_q    <= 1'b0;
            ifmap_q     <= '0;
            psum_q      <= '0;
            weight_q    <= '0;
            cfg_ready_q <= 1'b0;
            in_ready_q  <= 1'b0;
            load_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            count_q     <= count_nxt;
            rem_q       <= rem_nxt;
            push_cnt_q  <= push_cnt_nxt;
            used_q      <= used_nxt;
            tag_q       <= tag_nxt;
            op_vld_q    <= acc;
            ifmap_q     <= ifmap_nxt;
            psum_q      <= psum_nxt;
            weight_q    <= weight_nxt;
            cfg_ready_q <= cfg_ready_nxt;
            in_ready_q  <= in_ready_nxt;
            load_en_q   <= load_en_nxt;
            busy_q      <= busy_nxt;
            done_q      <= done_nxt;
        end
    end

    pe_result_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({last_in, bus.pe_psum_out}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign bus.cfg_ready  = cfg_ready_q;
    assign bus.in_ready   = in_ready_q;
    assign bus.pe_load_en = load_en_q;
    assign bus.pe_weight  = weight_q;
    assign bus.pe_ifmap   = ifmap_q;
    assign bus.pe_psum    = psum_q;
    assign bus.out_valid  = fifo_ne;
    assign bus.out_data   = fifo_head[DATA_W-1:0];
    assign bus.out_last   = fifo_head[DATA_W];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: doc/pe_seq_ctrl.md
PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, FP16 word width.
REQ-002 SHALL have parameter CNT_W, default 8, element-count width.
REQ-003 SHALL have parameter PE_LAT, default 3, pe_fp16 cycles from ifmap_in/psum_in sample to psum_out.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, result buffer entries (power of two, >= 2).
REQ-005 SHALL have ports: clk  in  1  clock, rising edge; rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: cfg_valid in 1, cfg_ready out 1, cfg_weight in DATA_W, cfg_count in CNT_W (job request).
REQ-007 SHALL have ports: in_valid in 1, in_ready out 1, in_ifmap in DATA_W, in_psum in DATA_W (operand stream).
REQ-008 SHALL have ports: pe_load_en out 1, pe_weight out DATA_W, pe_ifmap out DATA_W, pe_psum out DATA_W, pe_psum_out in DATA_W (to/from pe_fp16).
REQ-009 SHALL have ports: out_valid out 1, out_ready in 1, out_data out DATA_W, out_last out 1 (result stream); busy out 1; done out 1.

Function
REQ-010 SHALL implement FSM IDLE -> LOAD -> STREAM -> DRAIN -> DONE -> IDLE.
REQ-011 IDLE: cfg_ready=1, busy=0; on cfg_valid capture weight and count, go LOAD; cfg_ready=0 in every other state.
REQ-012 LOAD: exactly one cycle, pe_load_en=1, pe_weight=captured weight; next STREAM if count!=0, else DRAIN.
REQ-013 pe_load_en SHALL be 0 and pe_weight 0 in every state except LOAD.
REQ-014 STREAM: in_ready=1 only when inflight+fifo_count < FIFO_DEPTH (credit); pop in same cycle does not add credit until next cycle.
REQ-015 On in_valid&in_ready, pe_ifmap/pe_psum SHALL be registered and present the operands for exactly the next cycle; otherwise they SHALL be 0 (bubble).
REQ-016 A PE_LAT-deep valid shift register SHALL tag each issued element; tag emerging SHALL push pe_psum_out into the result FIFO that cycle.
REQ-017 Remaining counter SHALL decrement per accept; accept of the last element SHALL move STREAM -> DRAIN, same edge.
REQ-018 out_valid = FIFO non-empty; out_data = FIFO head; pop on out_valid&out_ready; order preserved.
REQ-019 out_last SHALL be 1 with the job's final result only (result count == cfg_count).
REQ-020 DRAIN: go DONE on the cycle the last result pops (count=0: when shift register empty, immediately).
REQ-021 DONE: done=1 for exactly one cycle, then IDLE; busy=1 in LOAD, STREAM, DRAIN, DONE.
REQ-022 Simultaneous FIFO push and pop SHALL be legal at any occupancy; credit rule guarantees no overflow, no push is ever dropped.
REQ-023 in_valid outside STREAM SHALL be ignored (in_ready=0); cfg_valid outside IDLE ignored.
REQ-024 Data SHALL pass bit-exact; no FP arithmetic in this block.

Reset
REQ-025 On rst low, asynchronously: state IDLE, counters 0, shift register clear, FIFO empty.
REQ-026 During reset every output SHALL be 0 except cfg_ready=0; cfg_ready rises first cycle after release.
REQ-027 Reset mid-job SHALL discard inflight and buffered results; no out_valid or done after release.

Structure
REQ-028 FSM state encoding and default parameter constants SHALL live in shared package pe_ctrl_pkg.
REQ-029 Result buffer SHALL be sub-module pe_result_fifo (synchronous, DATA_W x FIFO_DEPTH, count output).
REQ-030 pe_fp16 SHALL NOT be instantiated inside; bench connects it externally.

Verification
REQ-031 cfg 3C00, count 2; ops (0000,4500),(4000,4200), out_ready=1 -> one load pulse; outs 4500, 4500, out_last on 2nd; done one cycle later.
REQ-032 cfg B800, count 2; ops (4400,4900),(C400,0000) -> outs 4800, 4000; first result PE_LAT+2 cycles after first accept.
REQ-033 cfg 4000, count 6, out_ready=0; stream (3C00,0000),(4000,0000),(4200,3C00),(3800,3800),… -> in_ready drops after 4 accepts; raise out_ready -> 4000,4400,4700,3E00 then remaining, no loss.
REQ-034 cfg 3C00, count 0 -> one pe_load_en pulse, no out_valid, done pulse, back to IDLE.
REQ-035 Assert rst low mid-STREAM with 2 inflight -> all outputs 0 at once; after release cfg_ready=1, no stale out_valid.
REQ-036 Bench SHALL check pe_ifmap/pe_psum equal 0 in every cycle without an accept in previous cycle.
